// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide engine and the ALU output mux.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
// Contents: default widths, op codes, FSM state type, MFHI/MFLO mux selects, op check.
package hilo_muldiv_unit_pkg;

  localparam int HILO_DATA_W = 32;
  localparam int HILO_CNT_W  = 5;

  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  // Select codes the ALU output mux uses to pick HI or LO.
  localparam logic [1:0] MFHI = 2'b10;
  localparam logic [1:0] MFLO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_valid_op(input logic [1:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Controller <-> HI/LO engine bundle: start/op/operands in, status and HI/LO out.
// Latency: n/a (wiring only).
// Backpressure: controller holds off new work while busy is high; start is a 1-cycle pulse.
// master: controller side (drives start/op/dataA/dataB); slave: engine side.
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] dataA;
  logic [DATA_W-1:0] dataB;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, dataA, dataB,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, dataA, dataB,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit_hilo_reg.sv
// Architectural HI/LO register pair; the ALU output mux reads hi_o/lo_o for MFHI/MFLO.
// Latency: 1 cycle from ld_i to hi_o/lo_o; values hold when ld_i is low.
// Backpressure: none, always accepts a load.
// Ports: clk, reset (async, active high), ld_i, hi_i, lo_i, hi_o, lo_o.
module hilo_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (ld_i) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULTU/DIVU engine (shift-add / restoring divide) writing the HI/LO pair.
// Latency: DATA_W cycles start->HI/LO write, done the following cycle; DIVU by 0 completes at the start edge.
// Backpressure: busy high during RUN; start is ignored unless idle or in the done cycle.
// Ports: clk, reset (async, active high), bus (slave modport: start/op/dataA/dataB in; busy/done/div_by_zero/hi/lo out).
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W,
  parameter int CNT_W  = HILO_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  hilo_muldiv_unit_if.slave bus
);

  localparam int AW = 2 * DATA_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              dbz_q, dbz_d;

  logic              ld;
  logic [DATA_W-1:0] ld_hi, ld_lo;
  logic [DATA_W-1:0] hi_w, lo_w;

  logic              accept;
  logic              start_div;

  // One iteration of each algorithm, computed from the current accumulator.
  logic [DATA_W:0]   mul_sum;
  logic [AW-1:0]     mul_nxt;
  logic              div_ge;
  logic [DATA_W-1:0] div_rem;
  logic [AW-1:0]     div_nxt;
  logic [AW-1:0]     acc_step;

  always_comb begin
    // Add into the upper half with the carry kept as bit DATA_W, then shift right.
    mul_sum = {1'b0, acc_q[AW-1:DATA_W]} + {1'b0, opnd_q};
    mul_nxt = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[AW-1:1]};

    // The upper 33 bits after the left shift are acc_q[AW-1:DATA_W-1]. When they
    // are >= divisor the difference is < divisor, so the low DATA_W bits suffice.
    div_ge  = acc_q[AW-1:DATA_W-1] >= {1'b0, opnd_q};
    div_rem = acc_q[AW-2:DATA_W-1] - opnd_q;
    div_nxt = div_ge ? {div_rem, acc_q[DATA_W-2:0], 1'b1} : {acc_q[AW-2:0], 1'b0};

    acc_step = is_div_q ? div_nxt : mul_nxt;
  end

  assign accept    = bus.start && is_valid_op(bus.op);
  assign start_div = (bus.op == OP_DIVU);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    ld       = 1'b0;
    ld_hi    = '0;
    ld_lo    = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          dbz_d    = 1'b0;
          cnt_d    = '0;
          is_div_d = start_div;
          if (start_div && (bus.dataB == '0)) begin
            // Divide by zero completes at the acceptance edge.
            ld      = 1'b1;
            ld_hi   = bus.dataA;
            ld_lo   = '1;
            dbz_d   = 1'b1;
            acc_d   = '0;
            opnd_d  = '0;
            state_d = ST_DONE;
          end else if (start_div) begin
            acc_d   = {{DATA_W{1'b0}}, bus.dataA};
            opnd_d  = bus.dataB;
            state_d = ST_RUN;
          end else begin
            acc_d   = {{DATA_W{1'b0}}, bus.dataB};
            opnd_d  = bus.dataA;
            state_d = ST_RUN;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          ld      = 1'b1;
          ld_hi   = acc_step[AW-1:DATA_W];
          ld_lo   = acc_step[DATA_W-1:0];
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      dbz_q    <= dbz_d;
    end
  end

  hilo_reg #(
    .DATA_W(DATA_W)
  ) u_hilo_reg (
    .clk   (clk),
    .reset (reset),
    .ld_i  (ld),
    .hi_i  (ld_hi),
    .lo_i  (ld_lo),
    .hi_o  (hi_w),
    .lo_o  (lo_w)
  );

  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_w;
  assign bus.lo          = lo_w;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit against an arithmetic reference.
// Latency: checks DATA_W-cycle completion, one-cycle done and zero-cycle divide by zero.
// Backpressure: exercises start during RUN, invalid ops and back-to-back starts in DONE.
module tb_hilo_muldiv_unit;

  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  logic clk = 1'b0;
  logic reset;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  hilo_muldiv_unit_if #(.DATA_W(32)) bus ();

  hilo_muldiv_unit #(
    .DATA_W(32),
    .CNT_W (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; edges from start to done.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dbz, output int lat);
    logic [63:0] p;
    dbz = 1'b0;
    lat = 32;
    if (op == OP_MULTU) begin
      p  = 64'(a) * 64'(b);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      dbz = 1'b1;
      lat = 0;
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.dataA = a;
    bus.dataB = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done (bounded) and checks timing and result; returns at the done sample.
  task automatic run_chk(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb);
    logic [31:0] mh, ml;
    logic        mdbz;
    int          mlat, lat, bn;
    model(op, a, b, mh, ml, mdbz, mlat);
    lat = 0;
    bn  = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bn++;
      if (disturb) begin
        bus.dataA = $urandom;
        bus.dataB = $urandom;
        bus.start = 1'($urandom % 2);
        bus.op    = 2'($urandom % 4);
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_lat"},  64'(lat),      64'(mlat));
    chk({tag, "_busyn"}, 64'(bn),      64'(mlat));
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hi"},   64'(bus.hi),   64'(mh));
    chk({tag, "_lo"},   64'(bus.lo),   64'(ml));
    chk({tag, "_dbz"},  64'(bus.div_by_zero), 64'(mdbz));
    exp_hi = mh;
    exp_lo = ml;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          seen_done;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.dataA = '0;
    bus.dataB = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    chk("rst_hi",   64'(bus.hi), 64'd0);
    chk("rst_lo",   64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Max-operand multiply, then confirm done lasts one cycle and HI/LO hold.
    go(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_chk("mul_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mul_max_hi_lit", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    chk("mul_max_lo_lit", 64'(bus.lo), 64'h0000_0000_0000_0001);
    @(negedge clk);
    chk("done_1cyc", 64'(bus.done), 64'd0);
    repeat (3) @(negedge clk);
    chk("hold_hi", 64'(bus.hi), 64'(exp_hi));
    chk("hold_lo", 64'(bus.lo), 64'(exp_lo));

    go(OP_DIVU, 32'd100, 32'd7);
    run_chk("div_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
    chk("div_100_7_lo_lit", 64'(bus.lo), 64'd14);
    chk("div_100_7_hi_lit", 64'(bus.hi), 64'd2);
    @(negedge clk);

    // Operands and start are scrambled throughout RUN; the result must not move.
    go(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    run_chk("div_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);

    // Divide by zero, then a back-to-back start in the done cycle clears the flag.
    go(OP_DIVU, 32'h1234_5678, 32'd0);
    run_chk("div0", OP_DIVU, 32'h1234_5678, 32'd0, 1'b0);
    go(OP_MULTU, 32'd3, 32'd5);
    chk("dbz_clr", 64'(bus.div_by_zero), 64'd0);
    run_chk("b2b_mul", OP_MULTU, 32'd3, 32'd5, 1'b0);
    @(negedge clk);

    // Invalid op in IDLE must not start anything.
    go(2'b11, 32'd9, 32'd9);
    repeat (3) begin
      chk("inv_busy", 64'(bus.busy), 64'd0);
      chk("inv_done", 64'(bus.done), 64'd0);
      @(negedge clk);
    end
    chk("inv_hi", 64'(bus.hi), 64'(exp_hi));
    chk("inv_lo", 64'(bus.lo), 64'(exp_lo));

    // Random operations, random disturbance, random back-to-back chaining.
    for (int i = 0; i < 24; i++) begin
      rop = ($urandom % 2 == 0) ? OP_MULTU : OP_DIVU;
      ra  = ($urandom % 8 == 0) ? 32'd0 : 32'($urandom);
      case ($urandom % 4)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom % 16);
        default: rb = 32'($urandom);
      endcase
      go(rop, ra, rb);
      run_chk($sformatf("rnd%0d", i), rop, ra, rb, 1'($urandom % 2));
      if ($urandom % 2 == 0) begin
        @(negedge clk);
        chk("rnd_idle_done", 64'(bus.done), 64'd0);
      end
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a multiply.
    go(OP_MULTU, 32'hDEAD_BEEF, 32'h0001_2345);
    run_chk("pre_rst", OP_MULTU, 32'hDEAD_BEEF, 32'h0001_2345, 1'b0);
    @(negedge clk);
    go(OP_MULTU, 32'd5, 32'd7);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_hi",   64'(bus.hi), 64'd0);
    chk("arst_lo",   64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("arst_no_done", 64'(seen_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative, multi-cycle MULTU/DIVU engine that writes the architectural HI/LO pair.
- It is the writer side of the HI/LO interface. The datapath's ALU output mux reads `hi`/`lo` for MFHI/MFLO.
- Sits beside the single-cycle ALU and takes the same dataA/dataB operands.
- The controller starts an operation with a one-cycle `start` and stalls on `busy` until `done`.

Parameters:
- DATA_W, 32, operand and HI/LO width; only 32 is supported.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == DATA_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE or DONE.
- op  input  2  operation: 2'b01 MULTU, 2'b10 DIVU; 2'b00/2'b11 are ignored (no operation started).
- dataA  input  DATA_W  multiplicand / dividend (unsigned).
- dataB  input  DATA_W  multiplier / divisor (unsigned).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle.
- div_by_zero  output  1  sticky until the next accepted start; set when a DIVU had dataB==0.
- hi  output  DATA_W  HI register: product[63:32] or remainder.
- lo  output  DATA_W  LO register: product[31:0] or quotient.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Counter and working registers are cleared; any in-flight operation is aborted with no partial result.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with a valid op latches operands and op, clears div_by_zero, counter=0, and goes to RUN.
  - Exception: DIVU with dataB==0 goes to DONE directly.
  - Invalid op: stay in IDLE.
- RUN: busy=1. One iteration per cycle, counter increments.
  - MULTU: shift-add over a 64-bit accumulator. Each cycle, if multiplier LSB=1, add the multiplicand to accumulator[63:32] with carry-out kept; then shift right by 1.
  - DIVU: restoring division on a 64-bit remainder/quotient register. Shift left 1, subtract divisor from the upper 33 bits; if the result is non-negative, keep it and set quotient bit=1, else restore.
  - When counter==DATA_W-1, the same edge writes hi/lo and moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge: if start=1 with a valid op, accept it (back-to-back, no idle cycle needed); otherwise go to IDLE.
- Latency:
  - Result is visible DATA_W cycles after the start edge; done is high in the cycle following that write.
  - With DATA_W=32, the start edge is E0, hi/lo are written at E32, and done is high between E32 and E33.
- Divide by zero:
  - Zero-cycle iteration: at the start edge, hi=dataA, lo=32'hFFFFFFFF, div_by_zero=1, state goes to DONE.
  - done pulses in the next cycle.
- start while in RUN is ignored; operands are captured only at acceptance, so changing dataA/dataB during RUN has no effect.
- hi/lo hold their value between operations and change only at the completing edge or on reset. MFHI/MFLO reads are valid whenever busy=0.
- MULTU with either operand 0: runs the full DATA_W cycles; result 0/0.

Decomposition:
- Shared include, alongside the ALU's existing Signal codes:
  - op encodings OP_MULTU=2'b01, OP_DIVU=2'b10.
  - state encodings ST_IDLE/ST_RUN/ST_DONE.
  - HI/LO mux select codes MFHI=2'b10, MFLO=2'b01.
- Sub-module: hilo_reg (a 2x DATA_W register pair with load enable and async reset). It is instanced here and its outputs are what the ALU output mux reads.
- The iteration datapath and FSM stay in hilo_muldiv_unit.

Test Plan:
- Reset: assert reset mid-RUN of MULTU 5x7. busy, done, hi and lo go to 0 immediately, asynchronously; after release, no done pulse appears.
- MULTU max operands: 32'hFFFFFFFF x 32'hFFFFFFFF. done arrives 32 cycles after start, with hi=32'hFFFFFFFE, lo=32'h00000001, busy high for exactly 32 cycles.
- DIVU: 100 / 7 gives lo=14, hi=2. DIVU 32'h80000000 / 32'hFFFFFFFF gives lo=0, hi=32'h80000000. Both with 32-cycle latency and div_by_zero=0.
- Divide by zero: DIVU 32'h12345678 / 0. done arrives the cycle after start, with hi=32'h12345678, lo=32'hFFFFFFFF and div_by_zero=1. The next valid start clears div_by_zero.
- Handshake edges:
  - start pulsed during RUN and op=2'b11 in IDLE are both ignored; result and timing are unchanged.
  - A start asserted in the DONE cycle is accepted, back-to-back.
  - dataA/dataB toggled during RUN do not alter the result.
